udp_rxbuf_reader: RTL

// - CPU-side consumer of the shared UDP RX buffer that the ROS2 core fills.
// - Waits for the CPU grant, reads the length word and the payload words, and streams the payload as

---
 rtl/udp_rxbuf_reader.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/udp_rxbuf_reader.sv
// CPU-side reader of the shared UDP RX buffer: fetches the length word and payload, streams bytes on AXI-stream.
// Optional statistics counters are enabled by defining UDP_RXBUF_READER_STATS_EN.
module udp_rxbuf_reader #(
    parameter int AWIDTH  = 9,
    parameter int MAX_LEN = 4 * ((1 << AWIDTH) - 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              udp_rxbuf_cpu_grant,
    output logic              udp_rxbuf_cpu_rel,
    output logic [AWIDTH-1:0] udp_rxbuf_addr,
    output logic              udp_rxbuf_ce,
    input  logic [31:0]       udp_rxbuf_rdata,
    output logic [7:0]        m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              m_axis_tuser,
    output logic [15:0]       pkt_len
`ifdef UDP_RXBUF_READER_STATS_EN
    ,
    output logic [15:0]       pkt_count,
    output logic [15:0]       err_count
`endif
);

    localparam logic [15:0] MAX_LEN16 = 16'(MAX_LEN);

    typedef enum logic [3:0] {
        S_IDLE, S_HDR, S_HDR_CAP, S_FETCH, S_LOAD, S_STREAM, S_REL, S_DRAIN, S_ABORT
    } state_t;

    state_t              r_state;
    logic [AWIDTH-1:0]   r_ptr;
    logic [AWIDTH-1:0]   r_addr;
    logic [15:0]         r_cnt;
    logic [15:0]         r_len;
    logic [31:0]         r_word;
    logic [1:0]          r_lane;
    logic                r_err;
    logic                r_rel;
    logic                r_ce;
    logic [7:0]          r_tdata;
    logic                r_tvalid;
    logic                r_tlast;
    logic                r_tuser;
`ifdef UDP_RXBUF_READER_STATS_EN
    logic [15:0]         r_pkt_count;
    logic [15:0]         r_err_count;
`endif

    logic [15:0]         w_hdr_len;
    logic                w_clamp;
    logic [15:0]         w_len_c;
    logic                w_hs;
    logic                w_stream_done;
    logic                w_abort;
    logic [1:0]          w_lane_inc;
    logic [AWIDTH-1:0]   w_ptr_inc;
    logic                w_load_last;
    logic                w_next_last;

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
        return word[{lane, 3'b000} +: 8];
    endfunction

    assign w_hdr_len     = udp_rxbuf_rdata[15:0];
    assign w_clamp       = (w_hdr_len > MAX_LEN16);
    assign w_len_c       = w_clamp ? MAX_LEN16 : w_hdr_len;
    assign w_hs          = r_tvalid & m_axis_tready;
    assign w_lane_inc    = r_lane + 2'd1;
    assign w_ptr_inc     = r_ptr + 1'b1;
    assign w_load_last   = ((r_cnt + 16'd1) == r_len);
    assign w_next_last   = ((r_cnt + 16'd2) == r_len);
    // A last-byte handshake wins over a simultaneous grant drop: the packet counts as completed.
    assign w_stream_done = (r_state == S_STREAM) && w_hs && r_tlast;
    assign w_abort       = !udp_rxbuf_cpu_grant && !w_stream_done &&
                           ((r_state == S_FETCH) || (r_state == S_LOAD) || (r_state == S_STREAM));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_addr   <= '0;
            r_cnt    <= '0;
            r_len    <= '0;
            r_word   <= '0;
            r_lane   <= '0;
            r_err    <= 1'b0;
            r_rel    <= 1'b0;
            r_ce     <= 1'b0;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tuser  <= 1'b0;
`ifdef UDP_RXBUF_READER_STATS_EN
            r_pkt_count <= '0;
            r_err_count <= '0;
`endif
        end else begin
            r_rel <= 1'b0;
            if (w_abort) begin
                // Buffer is no longer ours: terminate the packet with an error byte, never release.
                r_state  <= S_ABORT;
                r_ce     <= 1'b0;
                r_tvalid <= 1'b1;
                r_tdata  <= 8'h00;
                r_tlast  <= 1'b1;
                r_tuser  <= 1'b1;
`ifdef UDP_RXBUF_READER_STATS_EN
                r_err_count <= r_err_count + 16'd1;
`endif
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (udp_rxbuf_cpu_grant && enable) begin
                            r_state <= S_HDR;
                            r_ce    <= 1'b1;
                            r_addr  <= '0;
                        end
                    end
                    S_HDR: begin
                        r_ce    <= 1'b0;
                        r_state <= S_HDR_CAP;
                    end
                    S_HDR_CAP: begin
                        r_len  <= w_len_c;
                        r_err  <= w_clamp;
                        r_cnt  <= '0;
                        r_lane <= '0;
`ifdef UDP_RXBUF_READER_STATS_EN
                        if (w_clamp) r_err_count <= r_err_count + 16'd1;
`endif
                        if (w_len_c == 16'd0) begin
                            r_state <= S_REL;
                            r_rel   <= 1'b1;
`ifdef UDP_RXBUF_READER_STATS_EN
                            r_pkt_count <= r_pkt_count + 16'd1;
`endif
                        end else begin
                            r_state <= S_FETCH;
                            r_ptr   <= AWIDTH'(1);
                            r_addr  <= AWIDTH'(1);
                            r_ce    <= 1'b1;
                        end
                    end
                    S_FETCH: begin
                        r_ce    <= 1'b0;
                        r_state <= S_LOAD;
                    end
                    S_LOAD: begin
                        r_word   <= udp_rxbuf_rdata;
                        r_tvalid <= 1'b1;
                        r_tdata  <= lane_byte(udp_rxbuf_rdata, r_lane);
                        r_tlast  <= w_load_last;
                        r_tuser  <= r_err & w_load_last;
                        r_state  <= S_STREAM;
                    end
                    S_STREAM: begin
                        if (w_stream_done) begin
                            r_cnt    <= r_cnt + 16'd1;
                            r_tvalid <= 1'b0;
                            r_tlast  <= 1'b0;
                            r_tuser  <= 1'b0;
                            r_tdata  <= 8'h00;
                            r_rel    <= 1'b1;
                            r_state  <= S_REL;
`ifdef UDP_RXBUF_READER_STATS_EN
                            r_pkt_count <= r_pkt_count + 16'd1;
`endif
                        end else if (w_hs) begin
                            r_cnt <= r_cnt + 16'd1;
                            if (r_lane == 2'd3) begin
                                r_tvalid <= 1'b0;
                                r_lane   <= 2'd0;
                                r_ptr    <= w_ptr_inc;
                                r_addr   <= w_ptr_inc;
                                r_ce     <= 1'b1;
                                r_state  <= S_FETCH;
                            end else begin
                                r_lane  <= w_lane_inc;
                                r_tdata <= lane_byte(r_word, w_lane_inc);
                                r_tlast <= w_next_last;
                                r_tuser <= r_err & w_next_last;
                            end
                        end
                    end
                    S_REL: begin
                        r_state <= S_DRAIN;
                    end
                    S_DRAIN: begin
                        // Hold off until the arbiter has taken the buffer back.
                        if (!udp_rxbuf_cpu_grant) r_state <= S_IDLE;
                    end
                    S_ABORT: begin
                        if (m_axis_tready) begin
                            r_tvalid <= 1'b0;
                            r_tlast  <= 1'b0;
                            r_tuser  <= 1'b0;
                            r_state  <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign udp_rxbuf_cpu_rel = r_rel;
    assign udp_rxbuf_addr    = r_addr;
    assign udp_rxbuf_ce      = r_ce;
    assign m_axis_tdata      = r_tdata;
    assign m_axis_tvalid     = r_tvalid;
    assign m_axis_tlast      = r_tlast;
    assign m_axis_tuser      = r_tuser;
    assign pkt_len           = r_len;
`ifdef UDP_RXBUF_READER_STATS_EN
    assign pkt_count         = r_pkt_count;
    assign err_count         = r_err_count;
`endif

endmodule
